// File: rtl/motors_ctrl_executor.sv
// Executes one motors command: sets the pen servo, waits for it to settle,
// then emits lockstep step/dir pulses on X and Y and signals completion.
module motors_ctrl_executor #(
    parameter int unsigned PULSE_NUM_WIDTH = 16,
    parameter int unsigned PULSE_PERIOD    = 4,
    parameter int unsigned SERVO_SETTLE    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       trigger,
    input  logic [PULSE_NUM_WIDTH-1:0] pulse_num_x,
    input  logic [PULSE_NUM_WIDTH-1:0] pulse_num_y,
    input  logic                       servo_pos,
    output logic                       busy,
    output logic                       done,
    output logic                       step_x,
    output logic                       step_y,
    output logic                       dir_x,
    output logic                       dir_y,
    output logic                       servo_out
);

    localparam int unsigned W    = PULSE_NUM_WIDTH;
    localparam int unsigned PC_W = (PULSE_PERIOD > 1) ? $clog2(PULSE_PERIOD) : 1;
    localparam int unsigned SC_W = $clog2(SERVO_SETTLE + 1);
    localparam logic SERVO_POS_UP = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVO_WAIT,
        ST_STEP,
        ST_DONE
    } state_e;

    state_e          state_q;
    logic [W-1:0]    rem_x_q;
    logic [W-1:0]    rem_y_q;
    logic [PC_W-1:0] pc_q;
    logic [SC_W-1:0] settle_q;
    logic            dir_x_q;
    logic            dir_y_q;
    logic            servo_q;

    logic pc_zero;
    logic rem_any;

    // Magnitude as unsigned W bits; the most negative value maps to 2^(W-1).
    function automatic logic [W-1:0] abs_val(input logic [W-1:0] v);
        return v[W-1] ? (~v + W'(1)) : v;
    endfunction

    assign pc_zero = (pc_q == '0);
    assign rem_any = (rem_x_q != '0) || (rem_y_q != '0);

    // Outputs decoded purely from registered state.
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign step_x    = (state_q == ST_STEP) && pc_zero && (rem_x_q != '0);
    assign step_y    = (state_q == ST_STEP) && pc_zero && (rem_y_q != '0);
    assign dir_x     = dir_x_q;
    assign dir_y     = dir_y_q;
    assign servo_out = servo_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rem_x_q  <= '0;
            rem_y_q  <= '0;
            pc_q     <= '0;
            settle_q <= '0;
            dir_x_q  <= 1'b1;
            dir_y_q  <= 1'b1;
            servo_q  <= SERVO_POS_UP;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        rem_x_q <= abs_val(pulse_num_x);
                        rem_y_q <= abs_val(pulse_num_y);
                        dir_x_q <= ~pulse_num_x[W-1];
                        dir_y_q <= ~pulse_num_y[W-1];
                        servo_q <= servo_pos;
                        pc_q    <= '0;
                        if (servo_pos != servo_q) begin
                            settle_q <= SC_W'(SERVO_SETTLE - 1);
                            state_q  <= ST_SERVO_WAIT;
                        end else begin
                            state_q  <= ST_STEP;
                        end
                    end
                end
                ST_SERVO_WAIT: begin
                    if (settle_q == '0) begin
                        pc_q    <= '0;
                        state_q <= ST_STEP;
                    end else begin
                        settle_q <= settle_q - SC_W'(1);
                    end
                end
                ST_STEP: begin
                    // Both counts exhausted at a period boundary ends the move.
                    if (pc_zero && !rem_any) begin
                        state_q <= ST_DONE;
                    end else begin
                        if (pc_zero && (rem_x_q != '0)) begin
                            rem_x_q <= rem_x_q - W'(1);
                        end
                        if (pc_zero && (rem_y_q != '0)) begin
                            rem_y_q <= rem_y_q - W'(1);
                        end
                        pc_q <= (pc_q == PC_W'(PULSE_PERIOD - 1)) ? '0 : pc_q + PC_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motors_ctrl_executor.sv
// Self-checking bench for motors_ctrl_executor: per-cycle timeline model plus
// directed commands with hand-computed latencies and pulse counts.
module tb_motors_ctrl_executor;

    localparam int P      = 4;
    localparam int SETTLE = 8;
    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic trig = 1'b0;
    logic signed [15:0] px = '0;
    logic signed [15:0] py = '0;
    logic sp = UP;
    logic busy, done, step_x, step_y, dir_x, dir_y, servo_out;

    logic trig2 = 1'b0;
    logic signed [15:0] px2 = '0;
    logic signed [15:0] py2 = '0;
    logic sp2 = UP;
    logic busy2, done2, step_x2, step_y2, dir_x2, dir_y2, servo_out2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    motors_ctrl_executor #(.PULSE_NUM_WIDTH(16), .PULSE_PERIOD(P), .SERVO_SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset), .trigger(trig),
        .pulse_num_x(px), .pulse_num_y(py), .servo_pos(sp),
        .busy(busy), .done(done), .step_x(step_x), .step_y(step_y),
        .dir_x(dir_x), .dir_y(dir_y), .servo_out(servo_out)
    );

    motors_ctrl_executor #(.PULSE_NUM_WIDTH(16), .PULSE_PERIOD(2), .SERVO_SETTLE(1)) dut_wide (
        .clk(clk), .reset(reset), .trigger(trig2),
        .pulse_num_x(px2), .pulse_num_y(py2), .servo_pos(sp2),
        .busy(busy2), .done(done2), .step_x(step_x2), .step_y(step_y2),
        .dir_x(dir_x2), .dir_y(dir_y2), .servo_out(servo_out2)
    );

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Timeline model: one accepted command described by its start edge and counts.
    int   ecnt = 0;
    int   e0 = 0;
    int   m_s = 0;
    int   m_nx = 0;
    int   m_ny = 0;
    bit   has_cmd = 1'b0;
    logic m_dx = 1'b1;
    logic m_dy = 1'b1;
    logic m_servo = UP;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int dlen();
        int n;
        n = (m_nx > m_ny) ? m_nx : m_ny;
        return 1 + m_s + n * P + 1;
    endfunction

    function automatic bit m_busy(input int e);
        int rel;
        rel = e - e0 + 1;
        return has_cmd && (rel >= 1) && (rel <= dlen());
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            has_cmd = 1'b0;
            m_servo = UP;
            m_dx    = 1'b1;
            m_dy    = 1'b1;
            ecnt    = 0;
        end else begin
            bit prev;
            prev = m_busy(ecnt);
            ecnt++;
            if (trig && !prev) begin
                m_nx    = iabs(int'(px));
                m_ny    = iabs(int'(py));
                m_dx    = (px >= 0);
                m_dy    = (py >= 0);
                m_s     = (sp != m_servo) ? SETTLE : 0;
                m_servo = sp;
                e0      = ecnt;
                has_cmd = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        int rel, st;
        logic eb, ed, esx, esy;
        rel = ecnt - e0 + 1;
        st  = rel - 1 - m_s;
        eb  = m_busy(ecnt);
        ed  = has_cmd && (rel == dlen());
        esx = eb && (st >= 0) && (st % P == 0) && (st / P < m_nx);
        esy = eb && (st >= 0) && (st % P == 0) && (st / P < m_ny);
        chk("busy", busy, eb);
        chk("done", done, ed);
        chk("step_x", step_x, esx);
        chk("step_y", step_y, esy);
        chk("dir_x", dir_x, m_dx);
        chk("dir_y", dir_y, m_dy);
        chk("servo_out", servo_out, m_servo);
    end

    task automatic send(input int x, input int y, input logic s);
        @(posedge clk);
        #1;
        px   = 16'(x);
        py   = 16'(y);
        sp   = s;
        trig = 1'b1;
        @(posedge clk);
        #1;
        trig = 1'b0;
    endtask

    task automatic watch(input int n, output int sx, output int sy, output int dn,
                         output int bz, output int dat, output int fst);
        sx = 0; sy = 0; dn = 0; bz = 0; dat = -1; fst = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (step_x) begin
                sx++;
                if (fst < 0) fst = i;
            end
            if (step_y) sy++;
            if (done) begin
                dn++;
                dat = i;
            end
            if (busy) bz++;
        end
    endtask

    initial begin
        int sx, sy, dn, bz, dat, fst;
        int d_first, d_second, sx_tot, sy_tot;
        int i2, sx2, sy2, bz2, d2at;

        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_dir_x", dir_x, 1);
        chk("rst_dir_y", dir_y, 1);
        chk("rst_servo", servo_out, UP);
        @(posedge clk);
        #1 reset = 1'b0;

        // x=3, y=-2, servo unchanged
        send(3, -2, UP);
        watch(16, sx, sy, dn, bz, dat, fst);
        chk("t1_sx", sx, 3);
        chk("t1_sy", sy, 2);
        chk("t1_done_at", dat, 14);
        chk("t1_done_cnt", dn, 1);
        chk("t1_busy_cycles", bz, 14);
        chk("t1_first_step", fst, 1);
        chk("t1_dir_x", dir_x, 1);
        chk("t1_dir_y", dir_y, 0);

        // servo change to DOWN, x=1
        send(1, 0, DOWN);
        watch(16, sx, sy, dn, bz, dat, fst);
        chk("t2_sx", sx, 1);
        chk("t2_sy", sy, 0);
        chk("t2_done_at", dat, 14);
        chk("t2_busy_cycles", bz, 14);
        chk("t2_first_step", fst, 9);
        chk("t2_servo", servo_out, DOWN);

        // zero move, servo unchanged
        send(0, 0, DOWN);
        watch(5, sx, sy, dn, bz, dat, fst);
        chk("t3_sx", sx + sy, 0);
        chk("t3_done_at", dat, 2);
        chk("t3_busy_cycles", bz, 2);

        // retrigger during busy and during DONE; accepted the cycle after
        send(2, 1, DOWN);
        d_first = -1; d_second = -1; sx_tot = 0; sy_tot = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (step_x) sx_tot++;
            if (step_y) sy_tot++;
            if (done) begin
                if (d_first < 0) d_first = c;
                else d_second = c;
            end
            @(posedge clk);
            #1;
            trig = 1'b0;
            if (c + 1 == 3)       begin px = 16'sd7; py = 16'sd7; sp = UP;   trig = 1'b1; end
            else if (c + 1 == 10) begin px = 16'sd5; py = 16'sd5; sp = UP;   trig = 1'b1; end
            else if (c + 1 == 11) begin px = 16'sd1; py = 16'sd0; sp = DOWN; trig = 1'b1; end
        end
        trig = 1'b0;
        chk("t4_done_first", d_first, 10);
        chk("t4_done_second", d_second, 17);
        chk("t4_sx", sx_tot, 3);
        chk("t4_sy", sy_tot, 1);
        chk("t4_servo", servo_out, DOWN);

        // reset after 2 of 5 steps
        send(-5, 5, DOWN);
        watch(6, sx, sy, dn, bz, dat, fst);
        chk("t5_sx_before", sx, 2);
        chk("t5_dir_x_before", dir_x, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_step", step_x | step_y, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_dir_x", dir_x, 1);
        chk("t5_rst_servo", servo_out, UP);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        watch(20, sx, sy, dn, bz, dat, fst);
        chk("t5_no_done", dn, 0);
        chk("t5_no_steps", sx + sy, 0);
        send(2, 0, UP);
        watch(12, sx, sy, dn, bz, dat, fst);
        chk("t5_new_sx", sx, 2);
        chk("t5_new_done_at", dat, 10);

        // most negative count on the fast instance (PULSE_PERIOD=2)
        @(posedge clk);
        #1;
        px2   = 16'sh8000;
        trig2 = 1'b1;
        @(posedge clk);
        #1 trig2 = 1'b0;
        i2 = 0; sx2 = 0; sy2 = 0; bz2 = 0; d2at = -1;
        while (i2 < 70000 && !(d2at > 0 && i2 > d2at)) begin
            @(negedge clk);
            i2++;
            if (i2 == 1) chk("t6_dir_x", dir_x2, 0);
            if (step_x2) sx2++;
            if (step_y2) sy2++;
            if (busy2) bz2++;
            if (done2 && d2at < 0) d2at = i2;
        end
        chk("t6_sx", sx2, 32768);
        chk("t6_sy", sy2, 0);
        chk("t6_done_at", d2at, 65538);
        chk("t6_busy_cycles", bz2, 65538);
        chk("t6_dir_y", dir_y2, 1);
        chk("t6_servo", servo_out2, UP);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
